// File: rtl/cmp_share_arbiter_if.sv
// cmp_share_arbiter_if: request/grant operand bus and valid/ready result bus
// shared between NREQ client blocks and the compare arbiter.
// master = client side, slave = arbiter side.
interface cmp_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  equal;
  logic                  greater;
  logic                  lower;

  modport master (
    output req, a_in, b_in, rsp_ready,
    input  gnt, busy, rsp_valid, rsp_id, equal, greater, lower
  );

  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output gnt, busy, rsp_valid, rsp_id, equal, greater, lower
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: one registered unsigned magnitude comparator shared
// round-robin between NREQ requesters. One compare in flight at a time:
// IDLE (grant + operand capture) -> CMP (flags registered) -> RESP (hold
// result until rsp_ready). All outputs come straight from registers.
// Optional feature: define CMP_SHARE_STATS_EN to add the saturating 16-bit
// cmp_count output counting accepted results.
module cmp_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  cmp_share_arbiter_if.slave bus
`ifdef CMP_SHARE_STATS_EN
  ,
  output logic [15:0]        cmp_count
`endif
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_rrPtr;
  logic [IDW-1:0]   r_curId;
  logic [IDW-1:0]   r_rspId;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_busy;
  logic             r_rspValid;
  logic             r_equal;
  logic             r_greater;
  logic             r_lower;

  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_cand;
  logic [IDW-1:0]   w_nextPtr;
  logic [NREQ-1:0]  w_gntVec;
  logic [WIDTH-1:0] w_selA;
  logic [WIDTH-1:0] w_selB;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDW'((int'(r_rrPtr) + k) % NREQ);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Decode the winner into a one-hot grant and mux out its operand slices.
  always_comb begin
    w_gntVec  = '0;
    w_selA    = '0;
    w_selB    = '0;
    w_nextPtr = (w_pick == IDW'(NREQ - 1)) ? '0 : w_pick + IDW'(1);
    for (int i = 0; i < NREQ; i++) begin
      w_gntVec[i] = w_found && (w_pick == IDW'(i));
      if (w_pick == IDW'(i)) begin
        w_selA = bus.a_in[i*WIDTH +: WIDTH];
        w_selB = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Main sequencer: grant/capture, compare, then hold the result for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rrPtr    <= '0;
      r_curId    <= '0;
      r_rspId    <= '0;
      r_gnt      <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_busy     <= 1'b0;
      r_rspValid <= 1'b0;
      r_equal    <= 1'b0;
      r_greater  <= 1'b0;
      r_lower    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gnt <= w_gntVec;
          if (w_found) begin
            r_opA   <= w_selA;
            r_opB   <= w_selB;
            r_curId <= w_pick;
            r_rrPtr <= w_nextPtr;
            r_busy  <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_gnt      <= '0;
          r_equal    <= (r_opA == r_opB);
          r_greater  <= (r_opA >  r_opB);
          r_lower    <= (r_opA <  r_opB);
          r_rspId    <= r_curId;
          r_rspValid <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_gnt      <= '0;
          r_busy     <= 1'b0;
          r_rspValid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_id    = r_rspId;
  assign bus.equal     = r_equal;
  assign bus.greater   = r_greater;
  assign bus.lower     = r_lower;

`ifdef CMP_SHARE_STATS_EN
  logic [15:0] r_cmpCount;

  // Count accepted results, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmpCount <= '0;
    end else if (r_rspValid && bus.rsp_ready && (r_cmpCount != 16'hFFFF)) begin
      r_cmpCount <= r_cmpCount + 16'd1;
    end
  end

  assign cmp_count = r_cmpCount;
`endif
endmodule
